// File: rtl/lookback_cmul_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : lookback_cmul_scheduler_if
//  Purpose  : Bundles the frame control, shared-multiplier operand/result and
//             lookback accumulator signals of lookback_cmul_scheduler.
//  Signals  : frame_start_i  one-cycle pulse per downsampled sample
//             ch_en_i        channel enable mask, captured on accepted frame
//             clr_overrun_i  synchronous clear of the overrun flag
//             mul_resR_i     signed real part of the shared multiplier result
//             ch_sel_o       channel index driving the operand muxes
//             op_valid_o     operands for ch_sel_o are valid this cycle
//             acc_out_o      saturated lookback sum, held between frames
//             acc_valid_o    one-cycle pulse when acc_out_o is updated
//             busy_o         frame in progress (issuing or draining)
//             overrun_o      sticky: frame_start_i arrived while busy
//  Modports : slave  - the scheduler
//             master - the surrounding filter / stimulus side
//  Revision : 1.0  initial release
// ============================================================================
interface lookback_cmul_scheduler_if #(
    parameter int N_CH  = 4,
    parameter int W     = 25,
    parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic                frame_start_i;
    logic [N_CH-1:0]     ch_en_i;
    logic                clr_overrun_i;
    logic signed [W-1:0] mul_resR_i;
    logic [SEL_W-1:0]    ch_sel_o;
    logic                op_valid_o;
    logic signed [W-1:0] acc_out_o;
    logic                acc_valid_o;
    logic                busy_o;
    logic                overrun_o;

    modport slave (
        input  frame_start_i, ch_en_i, clr_overrun_i, mul_resR_i,
        output ch_sel_o, op_valid_o, acc_out_o, acc_valid_o, busy_o, overrun_o
    );

    modport master (
        output frame_start_i, ch_en_i, clr_overrun_i, mul_resR_i,
        input  ch_sel_o, op_valid_o, acc_out_o, acc_valid_o, busy_o, overrun_o
    );
endinterface
`default_nettype wire

// File: rtl/lookback_cmul_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : lookback_cmul_scheduler
//  Purpose  : Time-multiplexes one shared complex multiplier across the N_CH
//             lookback recursion channels. Once per downsampled sample it
//             issues one operand pair per enabled channel (lowest index
//             first), accumulates the real parts of the returned products
//             with per-add saturation and publishes the sum with a one-cycle
//             valid pulse.
//  Ports    : clk_i   system clock, rising edge
//             rst_ni  asynchronous active-low reset
//             bus     lookback_cmul_scheduler_if.slave (frame control,
//                     operand select/strobe, product input, result/status)
//  Revision : 1.0  initial release
// ============================================================================
module lookback_cmul_scheduler #(
    parameter int N_CH    = 4,
    parameter int N_INT   = 9,
    parameter int N_MANT  = 15,
    parameter int MUL_LAT = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    lookback_cmul_scheduler_if.slave  bus
);
    localparam int           W         = N_INT + N_MANT + 1;
    localparam int           SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [W-1:0] C_ACC_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] C_ACC_MIN = {1'b1, {(W-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [N_CH-1:0]    mask_q, mask_d;
    logic [MUL_LAT-1:0] trk_q, trk_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [W-1:0]       acc_out_q, acc_out_d;
    logic               acc_valid_q, acc_valid_d;
    logic [SEL_W-1:0]   ch_sel_q;
    logic               overrun_q, overrun_d;

    logic               issue;
    logic               busy;
    logic               accept;
    logic [SEL_W-1:0]   ch_sel;
    logic [SEL_W-1:0]   sel_low;
    logic [N_CH-1:0]    mask_rest;
    logic               res_vld;
    logic [W:0]         sum_ext;
    logic [W-1:0]       acc_sum;

    // ------------------------------------------------------------------------
    // Channel picking: lowest set bit of the remaining mask
    // ------------------------------------------------------------------------
    always_comb begin
        sel_low = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                sel_low = SEL_W'(i);
            end
        end
    end

    // x & (x-1) drops exactly the lowest set bit
    assign mask_rest = mask_q & (mask_q - N_CH'(1));

    // ------------------------------------------------------------------------
    // In-flight tracker: op_valid delayed by the multiplier latency; its
    // output bit marks the cycle in which mul_resR_i belongs to this frame.
    // ------------------------------------------------------------------------
    generate
        if (MUL_LAT == 1) begin : g_trk_one
            assign trk_d = issue;
        end else begin : g_trk_multi
            assign trk_d = {trk_q[MUL_LAT-2:0], issue};
        end
    endgenerate

    assign res_vld = trk_q[MUL_LAT-1];

    // ------------------------------------------------------------------------
    // Saturating accumulate: one guard bit detects signed overflow
    // ------------------------------------------------------------------------
    assign sum_ext = {acc_q[W-1], acc_q} + {bus.mul_resR_i[W-1], bus.mul_resR_i};

    always_comb begin
        if (sum_ext[W] != sum_ext[W-1]) begin
            acc_sum = sum_ext[W] ? C_ACC_MIN : C_ACC_MAX;
        end else begin
            acc_sum = sum_ext[W-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            // DONE behaves like IDLE for frame acceptance so frames can run
            // back to back.
            S_IDLE, S_DONE: begin
                if (bus.frame_start_i) begin
                    state_d = (bus.ch_en_i != '0) ? S_ISSUE : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (mask_rest == '0) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave once the result in flight this cycle is the last one
                if (trk_d == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        issue  = (state_q == S_ISSUE);
        busy   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        ch_sel = issue ? sel_low : ch_sel_q;
    end

    assign accept = bus.frame_start_i && !busy;

    // ------------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------------
    always_comb begin
        mask_d    = mask_q;
        acc_d     = acc_q;
        acc_out_d = acc_out_q;
        overrun_d = overrun_q;

        if (accept) begin
            mask_d = bus.ch_en_i;
            acc_d  = '0;
        end else begin
            if (issue) begin
                mask_d = mask_rest;
            end
            if (res_vld) begin
                acc_d = acc_sum;
            end
        end

        // Result register is loaded on entry to DONE so that acc_out and
        // acc_valid are both presented during the DONE cycle.
        acc_valid_d = (state_d == S_DONE);
        if (state_d == S_DONE) begin
            acc_out_d = acc_d;
        end

        if (bus.clr_overrun_i) begin
            overrun_d = 1'b0;
        end
        if (bus.frame_start_i && busy) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q      <= '0;
            trk_q       <= '0;
            acc_q       <= '0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            ch_sel_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            trk_q       <= trk_d;
            acc_q       <= acc_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            ch_sel_q    <= ch_sel;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.ch_sel_o    = ch_sel;
    assign bus.op_valid_o  = issue;
    assign bus.acc_out_o   = acc_out_q;
    assign bus.acc_valid_o = acc_valid_q;
    assign bus.busy_o      = busy;
    assign bus.overrun_o   = overrun_q;

endmodule
`default_nettype wire
